// File: rtl/de0cv_pkg.sv
// Shared constants and types for the DE0-CV button front end.
// Default timings derive from the 50 MHz board clock.
package de0cv_pkg;
    localparam int CLK_HZ        = 50_000_000;
    localparam int CYCLES_PER_MS = CLK_HZ / 1000;

    localparam int DEBOUNCE_MS      = 20;
    localparam int REPEAT_DELAY_MS  = 500;
    localparam int REPEAT_PERIOD_MS = 100;

    localparam int DEBOUNCE_CYCLES_DEF      = DEBOUNCE_MS * CYCLES_PER_MS;
    localparam int REPEAT_DELAY_CYCLES_DEF  = REPEAT_DELAY_MS * CYCLES_PER_MS;
    localparam int REPEAT_PERIOD_CYCLES_DEF = REPEAT_PERIOD_MS * CYCLES_PER_MS;

    typedef logic [1:0] repeat_state_t;
    localparam repeat_state_t IDLE   = 2'd0;
    localparam repeat_state_t DELAY  = 2'd1;
    localparam repeat_state_t REPEAT = 2'd2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/button_debounce_channel.sv
// One key channel: 2-flop synchronizer, debounce, press/release strobes and
// auto-repeat step strobes. Every output is a flop.
module button_debounce_channel
    import de0cv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEF,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    input  logic repeat_en,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic step
);
    localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int TMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int TW   = cnt_width(TMAX);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD_CYCLES - 1);

    logic          s1, s2;
    logic [DW-1:0] db_cnt;
    repeat_state_t state;
    logic [TW-1:0] timer;

    logic differs, flip, flip_press, flip_release, expire, repeat_fire;

    always_comb begin
        differs      = (~s2) != pressed;
        flip         = differs && (db_cnt == DB_LAST);
        flip_press   = flip && !pressed;
        flip_release = flip && pressed;
        expire       = ((state == DELAY)  && (timer == DELAY_LAST)) ||
                       ((state == REPEAT) && (timer == PERIOD_LAST));
        // A release or a dropped enable on the expiry edge suppresses the repeat.
        repeat_fire  = expire && repeat_en && !flip_release;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1            <= 1'b1;
            s2            <= 1'b1;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step          <= 1'b0;
            state         <= IDLE;
            timer         <= '0;
        end else begin
            s1            <= button;
            s2            <= s1;
            press_pulse   <= flip_press;
            release_pulse <= flip_release;
            step          <= flip_press | repeat_fire;

            if (flip) begin
                pressed <= ~pressed;
                db_cnt  <= '0;
            end else if (differs) begin
                db_cnt  <= db_cnt + DW'(1);
            end else begin
                db_cnt  <= '0;
            end

            if (flip_release || !repeat_en) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (flip_press) begin
                            state <= DELAY;
                            timer <= '0;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (expire) begin
                            state <= REPEAT;
                            timer <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BUTTONS raw active-low keys into clean levels and strobes,
// one independent channel per key.
module button_conditioner
    import de0cv_pkg::*;
#(
    parameter int NUM_BUTTONS          = 4,
    parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEF,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEF
) (
    input  logic                   in_clk,
    input  logic                   in_reset_n,
    input  logic [NUM_BUTTONS-1:0] in_button,
    input  logic                   in_repeat_en,
    output logic [NUM_BUTTONS-1:0] out_pressed,
    output logic [NUM_BUTTONS-1:0] out_press_pulse,
    output logic [NUM_BUTTONS-1:0] out_release_pulse,
    output logic [NUM_BUTTONS-1:0] out_step
);
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_debounce_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
        ) u_ch (
            .clk          (in_clk),
            .reset_n      (in_reset_n),
            .button       (in_button[i]),
            .repeat_en    (in_repeat_en),
            .pressed      (out_pressed[i]),
            .press_pulse  (out_press_pulse[i]),
            .release_pulse(out_release_pulse[i]),
            .step         (out_step[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random key activity,
// checked every cycle against a timeline-based reference model.
module tb_button_conditioner;
    localparam int NB = 4;
    localparam int DB = 4;
    localparam int DL = 10;
    localparam int PR = 3;
    localparam int HMAX = 4096;

    logic          in_clk = 1'b0;
    logic          in_reset_n;
    logic [NB-1:0] in_button;
    logic          in_repeat_en;
    logic [NB-1:0] out_pressed, out_press_pulse, out_release_pulse, out_step;

    button_conditioner #(
        .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY_CYCLES(DL), .REPEAT_PERIOD_CYCLES(PR)
    ) dut (
        .in_clk(in_clk), .in_reset_n(in_reset_n), .in_button(in_button),
        .in_repeat_en(in_repeat_en), .out_pressed(out_pressed),
        .out_press_pulse(out_press_pulse), .out_release_pulse(out_release_pulse),
        .out_step(out_step)
    );

    always #5 in_clk = ~in_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: raw-key history, consecutive-mismatch run length, and
    // edges elapsed since the debounced press of a key still being repeated.
    bit            h1[NB], h2[NB], m_pr[NB], rep_on[NB];
    int            run_len[NB], since[NB];
    logic [NB-1:0] e_pressed, e_pp, e_rp, e_step;

    logic [NB-1:0] hist_step[HMAX], hist_pp[HMAX], hist_rp[HMAX], hist_pr[HMAX];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        bit key, fp, fr, rep;
        if (!in_reset_n) begin
            for (int i = 0; i < NB; i++) begin
                h1[i] = 1; h2[i] = 1; m_pr[i] = 0; rep_on[i] = 0;
                run_len[i] = 0; since[i] = 0;
            end
            e_pressed = '0; e_pp = '0; e_rp = '0; e_step = '0;
            return;
        end
        for (int i = 0; i < NB; i++) begin
            key = !h2[i];
            h2[i] = h1[i];
            h1[i] = in_button[i];
            fp = 0; fr = 0; rep = 0;
            if (key != m_pr[i]) begin
                run_len[i]++;
                if (run_len[i] == DB) begin
                    m_pr[i] = key; run_len[i] = 0; fp = key; fr = !key;
                end
            end else begin
                run_len[i] = 0;
            end
            if (fr || !in_repeat_en) rep_on[i] = 0;
            else if (fp) begin rep_on[i] = 1; since[i] = 0; end
            else if (rep_on[i]) begin
                since[i]++;
                if (since[i] == DL || (since[i] > DL && (since[i] - DL) % PR == 0)) rep = 1;
            end
            e_pressed[i] = m_pr[i]; e_pp[i] = fp; e_rp[i] = fr; e_step[i] = fp | rep;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge in_clk);
            cyc++;
            model_step();
            @(negedge in_clk);
            chk("pressed", out_pressed, e_pressed);
            chk("press_pulse", out_press_pulse, e_pp);
            chk("release_pulse", out_release_pulse, e_rp);
            chk("step", out_step, e_step);
            if (cyc < HMAX) begin
                hist_step[cyc] = out_step; hist_pp[cyc] = out_press_pulse;
                hist_rp[cyc] = out_release_pulse; hist_pr[cyc] = out_pressed;
            end
        end
    endtask

    // Bit k = chosen output of channel ch observed after edge from+k.
    function automatic logic [63:0] mask_of(input int kind, input int ch, input int from);
        logic [63:0] m = '0;
        for (int k = 0; k < 64; k++) begin
            int idx = from + k;
            if (idx <= cyc && idx < HMAX) begin
                case (kind)
                    0: m[k] = hist_step[idx][ch];
                    1: m[k] = hist_pp[idx][ch];
                    2: m[k] = hist_rp[idx][ch];
                    default: m[k] = hist_pr[idx][ch];
                endcase
            end
        end
        return m;
    endfunction

    function automatic logic [63:0] bit_at(input int k);
        return 64'd1 << k;
    endfunction

    initial begin
        int t, d;
        logic [63:0] act;
        in_reset_n = 0; in_button = '1; in_repeat_en = 0;
        for (int i = 0; i < HMAX; i++) begin
            hist_step[i] = '0; hist_pp[i] = '0; hist_rp[i] = '0; hist_pr[i] = '0;
        end

        // Reset
        run(2);
        chk("rst_outputs", {out_pressed, out_press_pulse, out_release_pulse, out_step}, 0);
        in_reset_n = 1;
        run(3);
        chk("post_rst_outputs", {out_pressed, out_press_pulse, out_release_pulse, out_step}, 0);

        // Clean press, no repeat
        t = cyc; in_button[1] = 0;
        run(20);
        chk("s2_press_pulse", mask_of(1, 1, t), bit_at(6));
        chk("s2_step", mask_of(0, 1, t), bit_at(6));
        chk("s2_pressed_edge", {hist_pr[t+5][1], hist_pr[t+6][1]}, 2'b01);
        in_button = '1;
        run(12);

        // Bounce shorter than the debounce window
        t = cyc;
        in_button[0] = 0; run(3);
        in_button[0] = 1; run(1);
        in_button[0] = 0; run(2);
        in_button[0] = 1; run(20);
        act = '0;
        for (int i = t; i <= cyc; i++)
            act |= 64'(hist_pr[i] | hist_pp[i] | hist_rp[i] | hist_step[i]);
        chk("s3_no_activity", act, 0);

        // Auto-repeat, release landing on a repeat expiry
        in_repeat_en = 1;
        t = cyc; in_button[2] = 0;
        run(25);
        in_button[2] = 1;
        run(20);
        chk("s4_steps", mask_of(0, 2, t),
            bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22) | bit_at(25) | bit_at(28));
        chk("s4_release", mask_of(2, 2, t), bit_at(31));
        chk("s4_pressed_after", hist_pr[t+31][2], 1'b0);

        // Two keys together, enable dropped mid-repeat
        t = cyc; in_button = 4'b0110;
        run(18);
        in_repeat_en = 0;
        run(20);
        chk("s5_press_k0", mask_of(1, 0, t), bit_at(6));
        chk("s5_press_k3", mask_of(1, 3, t), bit_at(6));
        chk("s5_steps_k0", mask_of(0, 0, t), bit_at(6) | bit_at(16));
        chk("s5_steps_k3", mask_of(0, 3, t), bit_at(6) | bit_at(16));
        in_button = '1;
        run(10);

        // Reset while repeating
        in_repeat_en = 1;
        t = cyc; in_button[2] = 0;
        run(20);
        in_reset_n = 0;
        run(1);
        chk("s6_rst_outputs", {out_pressed, out_press_pulse, out_release_pulse, out_step}, 0);
        run(1);
        in_reset_n = 1;
        d = cyc;
        run(10);
        chk("s6_repress", mask_of(1, 2, d), bit_at(6));
        chk("s6_no_release", mask_of(2, 2, t), 0);
        in_button = '1;
        run(10);

        // Random activity
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 7) == 0) in_button[i] = ~in_button[i];
            if ($urandom_range(0, 29) == 0) in_repeat_en = ~in_repeat_en;
            in_reset_n = ($urandom_range(0, 149) != 0);
            run(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
